// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions for the front end: architectural widths,
//   RISC-V opcodes used by fetch predecode, and the fetch-buffer entry type.
//   Optional macro IFU_BTFN_PRED_EN adds the static-prediction helpers
//   (backward-taken / forward-not-taken, JAL always taken).
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One buffered instruction together with its pc and static next pc.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] snxt_pc;
  } fetch_entry_t;

`ifdef IFU_BTFN_PRED_EN
  // JAL is always taken; a conditional branch is taken when its immediate is
  // negative (backward), which is simply the instruction's top bit.
  function automatic logic btfn_taken(input logic [ILEN-1:0] instr);
    return (instr[6:0] == OPC_JAL) || ((instr[6:0] == OPC_BRANCH) && instr[31]);
  endfunction

  // Sign-extended J-type or B-type immediate, whichever the opcode selects.
  function automatic logic [XLEN-1:0] btfn_offset(input logic [ILEN-1:0] instr);
    if (instr[6:0] == OPC_JAL)
      return {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    return {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction
`endif

endpackage

// File: rtl/ifu_ibuf.sv
// ---------------------------------------------------------------------------
// ifu_ibuf
//   Instruction buffer: circular FIFO of fetch_entry_t, DEPTH a power of two.
//   The caller guarantees no push when full unless a pop happens the same
//   cycle. flush empties the buffer and wins over push/pop.
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         retire the head entry
//   flush       discard all entries
//   count       current occupancy (0..DEPTH)
//   head        entry at the head (meaningless when count == 0)
// ---------------------------------------------------------------------------
module ifu_ibuf
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap by overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone says which slots hold valid data.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Fetch stage. Issues in-order requests to instruction memory under a
//   credit limit (outstanding + buffered <= FIFO_DEPTH), buffers responses in
//   ifu_ibuf and presents the head to decode. Redirects flush the buffer and
//   drop responses still in flight for the abandoned path.
//   Optional macro IFU_BTFN_PRED_EN: predecode at push; JAL and backward
//   branches are predicted taken and fetch restarts at the target.
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   redirect_en, redirect_pc  EXU restart request and 4-byte aligned target
//   hazard_stall              decode holds the current head
//   imem_req/addr/gnt         request channel (accepted on req & gnt)
//   imem_rvalid/rdata         in-order response channel, always accepted
//   ifu_instr/pc/snxt_pc      head entry, zero when ifu_valid is low
//   ifu_valid                 head entry valid
// ---------------------------------------------------------------------------
module ifu_fetch
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hazard_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] ifu_instr,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] ifu_snxt_pc,
  output logic            ifu_valid
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  // run_q keeps imem_req low until the first clock edge after reset release.
  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            handshake;
  logic            resp_keep;
  logic            pop;
  logic            pred_taken;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Responses arriving during a redirect belong to the abandoned path.
    resp_keep   = imem_rvalid && !redirect_en && (drop_cnt_q == '0);

    push_entry.instr   = imem_rdata;
    push_entry.pc      = resp_pc_q;
    push_entry.snxt_pc = resp_pc_q + XLEN'(4);
    pred_taken         = 1'b0;
`ifdef IFU_BTFN_PRED_EN
    if (resp_keep && btfn_taken(imem_rdata)) begin
      pred_taken         = 1'b1;
      push_entry.snxt_pc = resp_pc_q + btfn_offset(imem_rdata);
    end
`endif

    // Credits cover both in-flight requests and buffered entries, so a
    // response can never find the buffer full.
    imem_req  = run_q && !redirect_en && !pred_taken && (credit_used < CREDITS);
    imem_addr = fetch_pc_q;
    handshake = imem_req && imem_gnt;

    ifu_valid = (fifo_count != '0);
    pop       = ifu_valid && !hazard_stall && !redirect_en;

    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(handshake) - CW'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q;
    if (handshake) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(4);
    if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);

    // Predicted-taken: every request behind the branch is on the wrong path.
    if (pred_taken) begin
      fetch_pc_d = push_entry.snxt_pc;
      resp_pc_d  = push_entry.snxt_pc;
      drop_cnt_d = outstanding_q - CW'(1);
    end

    // Redirect overrides everything; a response landing this cycle is one
    // fewer to drop later.
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end

    ifu_instr   = ifu_valid ? head.instr   : '0;
    ifu_pc      = ifu_valid ? head.pc      : '0;
    ifu_snxt_pc = ifu_valid ? head.snxt_pc : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifu_ibuf #(
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_en),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
//   Self-checking bench for ifu_fetch. A behavioural memory answers granted
//   requests in order after a chosen latency. A stream model tracks the next
//   pc decode must see and the next address fetch must request; a redirect
//   restarts both streams at the target. A cycle table covers reset release
//   and stalls, hand sequences cover credit exhaustion and redirect drops, and
//   a long random run exercises everything together.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk          = 1'b0;
  logic        rstn         = 1'b0;
  logic        redirect_en  = 1'b0;
  logic [63:0] redirect_pc  = '0;
  logic        hazard_stall = 1'b0;
  logic        imem_gnt     = 1'b0;
  logic        imem_rvalid  = 1'b0;
  logic [31:0] imem_rdata   = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] ifu_instr;
  logic [63:0] ifu_pc;
  logic [63:0] ifu_snxt_pc;
  logic        ifu_valid;

  ifu_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .hazard_stall (hazard_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ifu_instr    (ifu_instr),
    .ifu_pc       (ifu_pc),
    .ifu_snxt_pc  (ifu_snxt_pc),
    .ifu_valid    (ifu_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [63:0] addr;
    int          ready;
  } pend_t;

  pend_t pend[$];
  int    cyc       = 0;
  int    gnt_pct   = 100;
  int    lat_min   = 1;
  int    lat_max   = 1;
  bit    hold_resp = 1'b0;
  bit    btfn_img  = 1'b0;
  int    n_hs      = 0;

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    if (btfn_img && a == 64'h8000_0004) return 32'h0000_0463;  // beq x0,x0,+8
    if (btfn_img && a == 64'h8000_0010) return 32'hFE00_08E3;  // beq x0,x0,-16
    return {a[26:2] ^ 25'h0ABCDE1, 7'b0010011};                // OP-IMM filler
  endfunction

  // Architectural next pc of an instruction as fetch is expected to predict it.
  function automatic logic [63:0] exp_next(input logic [63:0] pc, input logic [31:0] ins);
    logic [63:0] nxt;
    nxt = pc + 64'd4;
`ifdef IFU_BTFN_PRED_EN
    if (ins[6:0] == 7'b1101111)
      nxt = pc + {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    else if (ins[6:0] == 7'b1100011 && ins[31])
      nxt = pc + {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
`endif
    return nxt;
  endfunction

  // ---------------- stream model ----------------
  logic [63:0] exp_fetch  = RST_PC;
  logic [63:0] exp_dec    = RST_PC;
  bit          chk_fetch  = 1'b1;
  bit          redir_prev = 1'b0;
  int          pops       = 0;

  // One clock: drive inputs after the edge, let logic settle, check, then
  // update memory and model with what happened in this cycle.
  task automatic cycle(input bit stall, input bit redir, input logic [63:0] rpc);
    bit hs;
    @(posedge clk);
    #1;
    cyc++;
    hazard_stall = stall;
    redirect_en  = redir;
    redirect_pc  = rpc;
    imem_gnt     = ($urandom_range(99) < gnt_pct);
    imem_rvalid  = !hold_resp && (pend.size() > 0) && (pend[0].ready <= cyc);
    if (imem_rvalid) imem_rdata = mem_fn(pend[0].addr);
    else             imem_rdata = $urandom;
    #1;
    hs = imem_req && imem_gnt;
    if (redir_prev) check("empty_after_redirect", ifu_valid, 0);
    if (redir)      check("no_req_in_redirect", imem_req, 0);
    if (!ifu_valid) check("zero_when_empty", ifu_pc | ifu_snxt_pc | {32'h0, ifu_instr}, 0);
    if (hs && chk_fetch) check("req_addr", imem_addr, exp_fetch);
    if (ifu_valid && !stall && !redir) begin
      check("dec_pc", ifu_pc, exp_dec);
      check("dec_instr", ifu_instr, mem_fn(exp_dec));
      check("dec_snxt", ifu_snxt_pc, exp_next(exp_dec, mem_fn(exp_dec)));
      exp_dec = exp_next(exp_dec, mem_fn(exp_dec));
      pops++;
    end
    if (hs) begin
      exp_fetch = exp_fetch + 64'd4;
      n_hs++;
    end
    if (redir) begin
      exp_fetch = rpc;
      exp_dec   = rpc;
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (hs) pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    check("credit_limit", pend.size() <= DEPTH, 1);
    redir_prev = redir;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn         = 1'b0;
    hazard_stall = 1'b0;
    redirect_en  = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", ifu_valid, 0);
    check("rst_out", ifu_pc | ifu_snxt_pc | {32'h0, ifu_instr}, 0);
    pend.delete();
    exp_fetch  = RST_PC;
    exp_dec    = RST_PC;
    redir_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("rel_req_low", imem_req, 0);
  endtask

  // ---------------- reset release / stall table ----------------
  typedef struct {
    bit          stall;
    bit          exp_valid;
    logic [63:0] exp_pc;
    bit          exp_req;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] rpc;
    int          hs0;

    vecs[0]  = '{1'b0, 1'b0, 64'h0,           1'b1};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,           1'b1};
    vecs[2]  = '{1'b0, 1'b1, 64'h8000_0000,   1'b1};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0004,   1'b1};
    vecs[4]  = '{1'b1, 1'b1, 64'h8000_0008,   1'b1};
    vecs[5]  = '{1'b1, 1'b1, 64'h8000_0008,   1'b1};
    vecs[6]  = '{1'b1, 1'b1, 64'h8000_0008,   1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'h8000_0008,   1'b0};
    vecs[8]  = '{1'b0, 1'b1, 64'h8000_000C,   1'b1};
    vecs[9]  = '{1'b0, 1'b1, 64'h8000_0010,   1'b1};
    vecs[10] = '{1'b0, 1'b1, 64'h8000_0014,   1'b1};
    vecs[11] = '{1'b0, 1'b1, 64'h8000_0018,   1'b1};

    // Streaming after reset, with a 3-cycle stall on head 0x80000008.
    gnt_pct = 100; lat_min = 1; lat_max = 1; hold_resp = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].stall, 1'b0, '0);
      check($sformatf("tbl_valid[%0d]", i), ifu_valid, vecs[i].exp_valid);
      check($sformatf("tbl_req[%0d]", i), imem_req, vecs[i].exp_req);
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl_pc[%0d]", i), ifu_pc, vecs[i].exp_pc);
        check($sformatf("tbl_snxt[%0d]", i), ifu_snxt_pc, vecs[i].exp_pc + 64'd4);
      end
    end

    // Responses withheld: exactly DEPTH requests, then credit exhaustion.
    do_reset();
    hold_resp = 1'b1;
    hs0 = n_hs;
    repeat (8) cycle(1'b0, 1'b0, '0);
    check("credit_hs_count", n_hs - hs0, DEPTH);
    check("credit_req_low", imem_req, 0);
    hold_resp = 1'b0;
    repeat (5) cycle(1'b1, 1'b0, '0);
    check("full_req_low", imem_req, 0);
    check("full_head", ifu_pc, RST_PC);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    check("credit_return_req", imem_req, 1);
    check("credit_return_addr", imem_addr, 64'h8000_0010);
    repeat (12) cycle(1'b0, 1'b0, '0);

    // Redirect with two in flight, the older returning in the redirect cycle.
    do_reset();
    lat_min = 2; lat_max = 2;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 64'h8000_1000);
    for (int i = 0; i < 10 && !ifu_valid; i++) cycle(1'b0, 1'b0, '0);
    check("redir_valid", ifu_valid, 1);
    check("redir_pc", ifu_pc, 64'h8000_1000);
    check("redir_snxt", ifu_snxt_pc, 64'h8000_1004);
    repeat (6) cycle(1'b0, 1'b0, '0);

`ifdef IFU_BTFN_PRED_EN
    // Static prediction: forward beq falls through, backward beq loops.
    btfn_img = 1'b1; chk_fetch = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30 && !(ifu_valid && ifu_pc == 64'h8000_0010); i++)
      cycle(1'b0, 1'b0, '0);
    check("bt_head_pc", ifu_pc, 64'h8000_0010);
    check("bt_snxt", ifu_snxt_pc, 64'h8000_0000);
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 10 && !ifu_valid; i++) cycle(1'b0, 1'b0, '0);
    check("bt_target_pc", ifu_pc, 64'h8000_0000);
    repeat (20) cycle(1'b0, 1'b0, '0);
    btfn_img = 1'b0; chk_fetch = 1'b1;
`endif

    // Random traffic against the stream model, with a mid-run async reset.
    do_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rpc = {$urandom, $urandom} & ~64'h3;
      cycle($urandom_range(99) < 25, $urandom_range(99) < 4, rpc);
    end
    check("progress", pops > 300, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
